lsu_handshake: RTL and testbench

Parametrised load/store unit for the RISC-V core's memory stage. Replaces the fixed single-cycle load path with a request/grant/response memory interface, so memory latency can be variable. Adds stores with byte strobes, XLEN-generic lane selection, misalignment detection and a response timeout. Sits between decode/execute operands and the data-memory port, and drives the register-file write port and PC stall.

---
 rtl/lsu_handshake.sv | 246 ++++++++++++++++++++++++
 tb/tb_lsu_handshake.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_handshake.sv
// Load/store unit for the memory stage.
// Request/grant/response port with byte strobes, misalignment and timeout.
module lsu_handshake #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic [XLEN-1:0]   imm,
  input  logic [4:0]        rd_in,
  input  logic [2:0]        load_control,
  input  logic [2:0]        store_control,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic              rd_write_control,
  output logic [4:0]        rd_out,
  output logic [XLEN-1:0]   rd_write_val,
  output logic              misalign_exc,
  output logic              bus_err,
  output logic [XLEN-1:0]   exc_addr
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [OW-1:0]     off_q, off_d;
  logic [1:0]        sz_q, sz_d;
  logic              sgn_q, sgn_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   ea_q, ea_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wc_q, wc_d;
  logic [4:0]        rdo_q, rdo_d;
  logic [XLEN-1:0]   val_q, val_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;
  logic [XLEN-1:0]   exc_q, exc_d;

  logic [XLEN-1:0]   ea;
  logic [OW-1:0]     off;
  logic              ld_v, st_v, sgn, mis, op_v;
  logic [1:0]        sz;
  logic [7:0]        mask;
  logic [XLEN-1:0]   lane, ld_val;

  assign ea  = rs1_val + imm;
  assign off = ea[OW-1:0];

  // Decode the incoming operation; loads win over stores.
  always_comb begin
    ld_v = 1'b0;
    st_v = 1'b0;
    sz   = 2'd0;
    sgn  = 1'b0;
    case (load_control)
      3'd1: begin ld_v = 1'b1; sz = 2'd0; sgn = 1'b1; end
      3'd2: begin ld_v = 1'b1; sz = 2'd1; sgn = 1'b1; end
      3'd3: begin ld_v = 1'b1; sz = 2'd2; sgn = 1'b1; end
      3'd4: begin ld_v = 1'b1; sz = 2'd0; end
      3'd5: begin ld_v = 1'b1; sz = 2'd1; end
      3'd6: begin ld_v = (XLEN == 64); sz = 2'd2; end
      3'd7: begin ld_v = (XLEN == 64); sz = 2'd3; end
      default: ;
    endcase
    if (load_control == 3'd0) begin
      case (store_control)
        3'd1: begin st_v = 1'b1; sz = 2'd0; end
        3'd2: begin st_v = 1'b1; sz = 2'd1; end
        3'd3: begin st_v = 1'b1; sz = 2'd2; end
        3'd4: begin st_v = (XLEN == 64); sz = 2'd3; end
        default: ;
      endcase
    end
  end

  assign op_v = ld_v | st_v;
  assign mis  = ((sz == 2'd1) & ea[0])
              | ((sz == 2'd2) & (|ea[1:0]))
              | ((sz == 2'd3) & (|ea[2:0]));

  // Byte-enable pattern for the access size before lane shifting.
  always_comb begin
    unique case (sz)
      2'd0: mask = 8'h01;
      2'd1: mask = 8'h03;
      2'd2: mask = 8'h0F;
      2'd3: mask = 8'hFF;
    endcase
  end

  // Pick the addressed lane from the response and extend it.
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    unique case (sz_q)
      2'd0: ld_val = sgn_q ? XLEN'($signed(lane[7:0]))
                           : XLEN'(lane[7:0]);
      2'd1: ld_val = sgn_q ? XLEN'($signed(lane[15:0]))
                           : XLEN'(lane[15:0]);
      2'd2: ld_val = sgn_q ? XLEN'($signed(lane[31:0]))
                           : XLEN'(lane[31:0]);
      2'd3: ld_val = lane;
    endcase
  end

  // Upstream holds while an op is accepted but not yet completing.
  always_comb begin
    unique case (state_q)
      IDLE:    stall_pc = op_v & ~mis;
      REQ:     stall_pc = ~(we_q & mem_gnt);
      RESP:    stall_pc = ~mem_rvalid;
      default: stall_pc = 1'b0;
    endcase
  end

  // Next-state and registered-output logic for the IDLE/REQ/RESP FSM.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    off_d   = off_q;
    sz_d    = sz_q;
    sgn_d   = sgn_q;
    rd_d    = rd_q;
    ea_d    = ea_q;
    cnt_d   = cnt_q;
    wc_d    = 1'b0;
    rdo_d   = rdo_q;
    val_d   = val_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (op_v && mis) begin
          mis_d = 1'b1;
          exc_d = ea;
        end else if (op_v) begin
          state_d = REQ;
          we_d    = st_v;
          addr_d  = {ea[XLEN-1:OW], {OW{1'b0}}};
          wdata_d = rs2_val << {off, 3'b000};
          wstrb_d = st_v ? (NB'(mask) << off) : '0;
          off_d   = off;
          sz_d    = sz;
          sgn_d   = sgn;
          rd_d    = rd_in;
          ea_d    = ea;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = we_q ? IDLE : RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          wc_d    = (rd_q != 5'd0);
          rdo_d   = rd_q;
          val_d   = ld_val;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          berr_d  = 1'b1;
          exc_d   = ea_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      sz_q    <= '0;
      sgn_q   <= 1'b0;
      rd_q    <= '0;
      ea_q    <= '0;
      cnt_q   <= '0;
      wc_q    <= 1'b0;
      rdo_q   <= '0;
      val_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      off_q   <= off_d;
      sz_q    <= sz_d;
      sgn_q   <= sgn_d;
      rd_q    <= rd_d;
      ea_q    <= ea_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      rdo_q   <= rdo_d;
      val_q   <= val_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      exc_q   <= exc_d;
    end
  end

  assign mem_req          = (state_q == REQ);
  assign mem_we           = mem_req & we_q;
  assign mem_addr         = mem_req ? addr_q : '0;
  assign mem_wdata        = mem_req ? wdata_q : '0;
  assign mem_wstrb        = mem_req ? wstrb_q : '0;
  assign rd_write_control = wc_q;
  assign rd_out           = rdo_q;
  assign rd_write_val     = val_q;
  assign misalign_exc     = mis_q;
  assign bus_err          = berr_q;
  assign exc_addr         = exc_q;

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench for lsu_handshake.
// Covers a 32-bit instance (short timeout) and a 64-bit instance.
module tb_lsu_handshake;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic [31:0] a_rs1, a_rs2, a_imm, a_rdata;
  logic [4:0]  a_rd;
  logic [2:0]  a_lc, a_sc;
  logic        a_gnt, a_rv;
  logic        a_stall, a_req, a_we, a_wc, a_mis, a_berr;
  logic [31:0] a_addr, a_wdata, a_val, a_exc;
  logic [3:0]  a_wstrb;
  logic [4:0]  a_rdo;

  logic [63:0] b_rs1, b_rs2, b_imm, b_rdata;
  logic [4:0]  b_rd;
  logic [2:0]  b_lc, b_sc;
  logic        b_gnt, b_rv;
  logic        b_stall, b_req, b_we, b_wc, b_mis, b_berr;
  logic [63:0] b_addr, b_wdata, b_val, b_exc;
  logic [7:0]  b_wstrb;
  logic [4:0]  b_rdo;

  int errs = 0;
  int checks = 0;

  lsu_handshake #(.XLEN(32), .TIMEOUT(4)) d32 (
    .i_clk(i_clk), .i_rst(i_rst),
    .rs1_val(a_rs1), .rs2_val(a_rs2), .imm(a_imm),
    .rd_in(a_rd), .load_control(a_lc), .store_control(a_sc),
    .mem_gnt(a_gnt), .mem_rvalid(a_rv), .mem_rdata(a_rdata),
    .stall_pc(a_stall), .mem_req(a_req), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
    .rd_write_control(a_wc), .rd_out(a_rdo),
    .rd_write_val(a_val), .misalign_exc(a_mis),
    .bus_err(a_berr), .exc_addr(a_exc)
  );

  lsu_handshake #(.XLEN(64), .TIMEOUT(16)) d64 (
    .i_clk(i_clk), .i_rst(i_rst),
    .rs1_val(b_rs1), .rs2_val(b_rs2), .imm(b_imm),
    .rd_in(b_rd), .load_control(b_lc), .store_control(b_sc),
    .mem_gnt(b_gnt), .mem_rvalid(b_rv), .mem_rdata(b_rdata),
    .stall_pc(b_stall), .mem_req(b_req), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
    .rd_write_control(b_wc), .rd_out(b_rdo),
    .rd_write_val(b_val), .misalign_exc(b_mis),
    .bus_err(b_berr), .exc_addr(b_exc)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp;
    @(negedge i_clk);
  endtask

  task automatic nop32;
    a_lc = 3'd0; a_sc = 3'd0; a_gnt = 1'b0; a_rv = 1'b0;
  endtask

  task automatic load32(input string tag,
                        input logic [31:0] rs1, input logic [31:0] imm,
                        input logic [2:0] lc, input logic [2:0] sc,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input logic [31:0] exp_addr,
                        input logic [31:0] exp, input logic expw);
    step;
    a_rs1 = rs1; a_imm = imm; a_lc = lc; a_sc = sc; a_rd = rd;
    a_rs2 = 32'hDEAD_BEEF; a_rdata = rdata; a_gnt = 1'b1; a_rv = 1'b1;
    smp;
    chk({tag, "_c0_stall"}, a_stall, 1);
    chk({tag, "_c0_req"}, a_req, 0);
    step; smp;
    chk({tag, "_c1_req"}, a_req, 1);
    chk({tag, "_c1_we"}, a_we, 0);
    chk({tag, "_c1_addr"}, a_addr, exp_addr);
    chk({tag, "_c1_stall"}, a_stall, 1);
    step; smp;
    chk({tag, "_c2_stall"}, a_stall, 0);
    chk({tag, "_c2_req"}, a_req, 0);
    step; nop32; smp;
    chk({tag, "_c3_wc"}, a_wc, expw);
    if (expw) begin
      chk({tag, "_c3_val"}, a_val, exp);
      chk({tag, "_c3_rd"}, a_rdo, rd);
    end
    step; smp;
    chk({tag, "_c4_wc"}, a_wc, 0);
  endtask

  task automatic load64(input string tag,
                        input logic [63:0] rs1, input logic [63:0] imm,
                        input logic [2:0] lc, input logic [4:0] rd,
                        input logic [63:0] rdata,
                        input logic [63:0] exp_addr,
                        input logic [63:0] exp);
    step;
    b_rs1 = rs1; b_imm = imm; b_lc = lc; b_sc = 3'd0; b_rd = rd;
    b_rdata = rdata; b_gnt = 1'b1; b_rv = 1'b1;
    step; smp;
    chk({tag, "_req"}, b_req, 1);
    chk({tag, "_addr"}, b_addr, exp_addr);
    step; step;
    b_lc = 3'd0; b_gnt = 1'b0; b_rv = 1'b0;
    smp;
    chk({tag, "_wc"}, b_wc, 1);
    chk({tag, "_val"}, b_val, exp);
  endtask

  initial begin
    i_rst = 1'b0;
    a_rs1 = '0; a_rs2 = '0; a_imm = '0; a_rdata = '0; a_rd = '0;
    nop32;
    b_rs1 = '0; b_rs2 = '0; b_imm = '0; b_rdata = '0; b_rd = '0;
    b_lc = '0; b_sc = '0; b_gnt = 1'b0; b_rv = 1'b0;
    #12;
    chk("rst_stall", a_stall, 0);
    chk("rst_req", a_req, 0);
    chk("rst_val", a_val, 0);
    chk("rst_exc", a_exc, 0);
    chk("rst_wc", a_wc, 0);
    chk("rst64_req", b_req, 0);
    smp;
    i_rst = 1'b1;

    load32("lb", 32'h100, 32'h3, 3'd1, 3'd0, 5'd5,
           32'h80FF_0000, 32'h100, 32'hFFFF_FF80, 1'b1);
    load32("lhu", 32'h100, 32'h2, 3'd5, 3'd0, 5'd6,
           32'hBEEF_1234, 32'h100, 32'h0000_BEEF, 1'b1);
    load32("lbu", 32'h200, 32'h1, 3'd4, 3'd0, 5'd4,
           32'h1122_C344, 32'h200, 32'h0000_00C3, 1'b1);
    load32("lw_sw", 32'h300, 32'h8, 3'd3, 3'd3, 5'd3,
           32'h7654_3210, 32'h308, 32'h7654_3210, 1'b1);
    load32("rd0", 32'h300, 32'h0, 3'd3, 3'd0, 5'd0,
           32'h1234_5678, 32'h300, 32'h0, 1'b0);

    // Misaligned LH: exception, no access.
    step;
    a_rs1 = 32'h100; a_imm = 32'h1; a_lc = 3'd2; a_rd = 5'd7;
    smp;
    chk("mis_stall", a_stall, 0);
    step; nop32; smp;
    chk("mis_exc", a_mis, 1);
    chk("mis_addr", a_exc, 32'h101);
    chk("mis_req", a_req, 0);
    chk("mis_wc", a_wc, 0);
    step; smp;
    chk("mis_pulse", a_mis, 0);
    chk("mis_req2", a_req, 0);

    // LWU is a NOP at XLEN=32.
    step;
    a_rs1 = 32'h100; a_imm = 32'h0; a_lc = 3'd6;
    smp;
    chk("lwu32_stall", a_stall, 0);
    step; nop32; smp;
    chk("lwu32_req", a_req, 0);

    // SH with grant in the third request cycle.
    step;
    a_rs1 = 32'h200; a_imm = 32'h2; a_sc = 3'd2;
    a_rs2 = 32'hAAAA_5678;
    smp;
    chk("sh_c0_stall", a_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      if (i == 2) a_gnt = 1'b1;
      smp;
      chk("sh_req", a_req, 1);
      chk("sh_we", a_we, 1);
      chk("sh_addr", a_addr, 32'h200);
      chk("sh_strb", a_wstrb, 4'b1100);
      chk("sh_wdata", a_wdata[31:16], 16'h5678);
      chk("sh_stall", a_stall, (i != 2));
    end
    step; nop32; smp;
    chk("sh_done_req", a_req, 0);
    chk("sh_done_stall", a_stall, 0);

    // LW with no response: bus error after four waiting cycles.
    step;
    a_rs1 = 32'h300; a_imm = 32'h0; a_lc = 3'd3; a_rd = 5'd7;
    a_gnt = 1'b1; a_rv = 1'b0;
    step; smp;
    chk("to_req", a_req, 1);
    for (int i = 0; i < 4; i++) begin
      step; smp;
      chk("to_wait_berr", a_berr, 0);
      chk("to_wait_stall", a_stall, 1);
    end
    step; nop32; smp;
    chk("to_berr", a_berr, 1);
    chk("to_exc", a_exc, 32'h300);
    chk("to_wc", a_wc, 0);
    chk("to_req_idle", a_req, 0);
    step; smp;
    chk("to_pulse", a_berr, 0);

    // Response on the last allowed cycle still succeeds.
    step;
    a_rs1 = 32'h304; a_imm = 32'h0; a_lc = 3'd3; a_rd = 5'd8;
    a_gnt = 1'b1; a_rv = 1'b0; a_rdata = 32'h0102_0304;
    step;
    for (int i = 0; i < 3; i++) step;
    step;
    a_rv = 1'b1;
    smp;
    chk("bd_stall", a_stall, 0);
    step; nop32; smp;
    chk("bd_wc", a_wc, 1);
    chk("bd_val", a_val, 32'h0102_0304);
    chk("bd_berr", a_berr, 0);

    // Reset during RESP drops everything.
    step;
    a_rs1 = 32'h400; a_imm = 32'h0; a_lc = 3'd3; a_rd = 5'd9;
    a_gnt = 1'b1; a_rv = 1'b0; a_rdata = 32'hCAFE_F00D;
    step; step; smp;
    chk("rr_resp_stall", a_stall, 1);
    #2;
    i_rst = 1'b0;
    #1;
    chk("rr_req", a_req, 0);
    chk("rr_val", a_val, 0);
    chk("rr_exc", a_exc, 0);
    nop32;
    smp;
    i_rst = 1'b1;
    step;
    a_rv = 1'b1;
    step; smp;
    chk("rr_late_wc", a_wc, 0);
    chk("rr_late_val", a_val, 0);
    a_rv = 1'b0;

    load64("lwu64", 64'h0, 64'h4, 3'd6, 5'd10,
           64'h8000_0001_1234_5678, 64'h0,
           64'h0000_0000_8000_0001);
    load64("lw64", 64'h0, 64'h4, 3'd3, 5'd11,
           64'h8000_0001_1234_5678, 64'h0,
           64'hFFFF_FFFF_8000_0001);
    load64("ld64", 64'h10, 64'h8, 3'd7, 5'd12,
           64'hFEDC_BA98_7654_3210, 64'h18,
           64'hFEDC_BA98_7654_3210);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
